seq_detect_param: RTL and testbench

Parametrised serial bit-pattern detector. It is the next generation of the board-level sequence detector. Each debounced press of the step button shifts in one data bit taken from a slide switch. The block tracks how much of the prefix has matched, using a generic prefix/suffix fallback instead of a hand-written state table. It flags a full match, counts matches, and supports runtime-selectable overlapping or non-overlapping detection.

---
 rtl/seq_detect_param.sv | 136 +++++++++++++
 tb/tb_seq_detect_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: synchronised, debounced step button
// shifts in one switch bit per press; prefix-match tracking with computed fallback.
module seq_detect_param #(
    parameter int unsigned               PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0]        PATTERN = 6'b101011,
    parameter int unsigned               DEB_CNT = 1000000,
    parameter int unsigned               CNT_W   = 8
) (
    input  logic                         System_clk,
    input  logic                         BTNU,
    input  logic                         BTND,
    input  logic                         SW1,
    input  logic                         overlap_en,
    output logic [$clog2(PAT_LEN+1)-1:0] LED,
    output logic                         LED0,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         step_pulse
);

    localparam int unsigned SW = $clog2(PAT_LEN + 1);
    localparam int unsigned DW = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;
    localparam int          PL = int'(PAT_LEN);

    // Pattern bit i in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(input int i);
        return 1'(PATTERN >> (PL - 1 - i));
    endfunction

    function automatic int unsigned border_len();
        int unsigned best;
        logic        ok;
        best = 0;
        for (int k = 1; k < PL; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (pat_bit(j) != pat_bit(PL - k + j)) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    // Longest pattern prefix that is a suffix of (first s pattern bits, then d).
    function automatic logic [SW-1:0] next_len(input logic [SW-1:0] s, input logic d);
        logic [SW-1:0] best;
        logic          ok;
        best = '0;
        for (int k = 1; k <= PL; k++) begin
            ok = (k <= int'(s) + 1) && (pat_bit(k - 1) == d);
            for (int j = 0; j < PL - 1; j++) begin
                if (ok && (j < k - 1) && (pat_bit(j) != pat_bit(int'(s) + 1 - k + j)))
                    ok = 1'b0;
            end
            if (ok) best = SW'(k);
        end
        return best;
    endfunction

    localparam int unsigned BORDER = border_len();

    logic          r_btnd_s1, r_btnd_s2;
    logic          r_sw_s1, r_sw_s2;
    logic [DW-1:0] r_deb_cnt;
    logic          r_level, r_level_d;
    logic          r_step;
    logic [SW-1:0] r_state;
    logic          r_led0;
    logic [CNT_W-1:0] r_mcnt;

    logic [SW-1:0] w_next;
    logic          w_match;

    assign w_next  = next_len(r_state, r_sw_s2);
    assign w_match = (w_next == SW'(PAT_LEN));

    // Input synchronisers and debounce of the step button.
    always_ff @(posedge System_clk or posedge BTNU) begin
        if (BTNU) begin
            r_btnd_s1 <= 1'b0;
            r_btnd_s2 <= 1'b0;
            r_sw_s1   <= 1'b0;
            r_sw_s2   <= 1'b0;
            r_deb_cnt <= '0;
            r_level   <= 1'b0;
        end else begin
            r_btnd_s1 <= BTND;
            r_btnd_s2 <= r_btnd_s1;
            r_sw_s1   <= SW1;
            r_sw_s2   <= r_sw_s1;
            if (r_btnd_s2 != r_level) begin
                if (r_deb_cnt == DW'(DEB_CNT - 1)) begin
                    r_level   <= r_btnd_s2;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + DW'(1);
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    // One-cycle strobe on the accepted rising edge of the button.
    always_ff @(posedge System_clk or posedge BTNU) begin
        if (BTNU) begin
            r_level_d <= 1'b0;
            r_step    <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_step    <= r_level & ~r_level_d;
        end
    end

    always_ff @(posedge System_clk or posedge BTNU) begin
        if (BTNU) begin
            r_state <= '0;
            r_led0  <= 1'b0;
            r_mcnt  <= '0;
        end else if (r_step) begin
            if (w_match) begin
                r_led0 <= 1'b1;
                if (r_mcnt != {CNT_W{1'b1}}) r_mcnt <= r_mcnt + CNT_W'(1);
                r_state <= overlap_en ? SW'(BORDER) : '0;
            end else begin
                r_led0  <= 1'b0;
                r_state <= w_next;
            end
        end
    end

    assign LED        = r_state;
    assign LED0       = r_led0;
    assign match_cnt  = r_mcnt;
    assign step_pulse = r_step;

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed vector tables, corner
// sequences and biased random steps against a history-based reference model.
module tb_seq_detect_param;

    localparam int         PL  = 6;
    localparam logic [5:0] PAT = 6'b101011;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btnd = 1'b0;
    logic sw1 = 1'b0;
    logic ov = 1'b1;

    logic [2:0] led8, led2;
    logic       led0_8, led0_2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic       sp8, sp2;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_LEN(6), .PATTERN(6'b101011), .DEB_CNT(4), .CNT_W(8)) u8 (
        .System_clk(clk), .BTNU(rst), .BTND(btnd), .SW1(sw1), .overlap_en(ov),
        .LED(led8), .LED0(led0_8), .match_cnt(cnt8), .step_pulse(sp8)
    );

    seq_detect_param #(.PAT_LEN(6), .PATTERN(6'b101011), .DEB_CNT(4), .CNT_W(2)) u2 (
        .System_clk(clk), .BTNU(rst), .BTND(btnd), .SW1(sw1), .overlap_en(ov),
        .LED(led2), .LED0(led0_2), .match_cnt(cnt2), .step_pulse(sp2)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int pulses = 0;

    always @(posedge clk) if (sp8) pulses++;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: keeps the raw bit history since reset / last
    // non-overlapping match and derives state from it directly.
    bit [31:0] hist;
    int        hlen, mled, mcnt8, mcnt2;
    bit        mled0;
    bit [5:0]  patv;

    task automatic model_reset();
        hist = '0; hlen = 0; mled = 0; mled0 = 1'b0; mcnt8 = 0; mcnt2 = 0;
    endtask

    task automatic model_step(input bit d, input bit ovv);
        hist = {hist[30:0], d};
        if (hlen < 32) hlen++;
        if (hlen >= PL && hist[PL-1:0] == PAT) begin
            mled0 = 1'b1;
            if (mcnt8 < 255) mcnt8++;
            if (mcnt2 < 3) mcnt2++;
            if (!ovv) hlen = 0;
        end else begin
            mled0 = 1'b0;
        end
        mled = 0;
        for (int k = 1; k < PL; k++)
            if (k <= hlen && ((hist & ((32'd1 << k) - 32'd1)) == (32'(PAT) >> (PL - k))))
                mled = k;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_led"},   int'(led8),   mled);
        chk({tag, "_led0"},  int'(led0_8), int'(mled0));
        chk({tag, "_cnt8"},  int'(cnt8),   mcnt8);
        chk({tag, "_led_w2"}, int'(led2),  mled);
        chk({tag, "_cnt2"},  int'(cnt2),   mcnt2);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        btnd = 1'b0;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(2);
    endtask

    task automatic press(input bit d, input bit ovv);
        int p0;
        sw1 = d;
        ov  = ovv;
        p0  = pulses;
        tick(3);
        btnd = 1'b1;
        tick(12);
        btnd = 1'b0;
        tick(12);
        chk("step_pulse_count", pulses - p0, 1);
        model_step(d, ovv);
    endtask

    typedef struct {
        bit rst_first;
        bit d;
        bit ov;
        int led;
        bit led0;
        int cnt;
    } vec_t;

    vec_t tv[$];

    task automatic add(input bit r, input bit d, input bit o, input int l, input bit l0, input int c);
        vec_t v;
        v.rst_first = r; v.d = d; v.ov = o; v.led = l; v.led0 = l0; v.cnt = c;
        tv.push_back(v);
    endtask

    initial begin
        int p0, lat, hi, n;
        bit found;
        int exp2[5];
        bit bits6[6];
        bit bits5[5];

        patv = PAT;
        model_reset();
        exp2[0] = 1; exp2[1] = 2; exp2[2] = 3; exp2[3] = 3; exp2[4] = 3;

        // Scenario 1: overlapping
        add(1,1,1,1,0,0); add(0,0,1,2,0,0); add(0,1,1,3,0,0); add(0,0,1,4,0,0);
        add(0,1,1,5,0,0); add(0,1,1,1,1,1); add(0,0,1,2,0,1); add(0,1,1,3,0,1);
        add(0,0,1,4,0,1); add(0,1,1,5,0,1); add(0,1,1,1,1,2);
        // Scenario 2: non-overlapping
        add(1,1,0,1,0,0); add(0,0,0,2,0,0); add(0,1,0,3,0,0); add(0,0,0,4,0,0);
        add(0,1,0,5,0,0); add(0,1,0,0,1,1); add(0,0,0,0,0,1); add(0,1,0,1,0,1);
        add(0,0,0,2,0,1); add(0,1,0,3,0,1); add(0,1,0,1,0,1);
        // Scenario 3: fallback to a non-zero prefix
        add(1,1,1,1,0,0); add(0,0,1,2,0,0); add(0,1,1,3,0,0); add(0,0,1,4,0,0);
        add(0,1,1,5,0,0); add(0,0,1,4,0,0); add(0,1,1,5,0,0); add(0,1,1,1,1,1);

        do_reset();
        chk("reset_led",  int'(led8),   0);
        chk("reset_led0", int'(led0_8), 0);
        chk("reset_cnt",  int'(cnt8),   0);
        chk("reset_step", int'(sp8),    0);

        foreach (tv[i]) begin
            if (tv[i].rst_first) do_reset();
            press(tv[i].d, tv[i].ov);
            chk($sformatf("vec%0d_led", i),  int'(led8),   tv[i].led);
            chk($sformatf("vec%0d_led0", i), int'(led0_8), int'(tv[i].led0));
            chk($sformatf("vec%0d_cnt", i),  int'(cnt8),   tv[i].cnt);
        end

        // Debounce: short glitch ignored, clean press with bouncy release gives one step
        do_reset();
        sw1 = 1'b1;
        ov  = 1'b1;
        tick(3);
        p0 = pulses;
        btnd = 1'b1;
        tick(3);
        btnd = 1'b0;
        tick(15);
        chk("glitch_no_step", pulses - p0, 0);
        chk("glitch_led", int'(led8), 0);
        btnd = 1'b1;
        lat = 0; hi = 0; found = 1'b0; n = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            n++;
            if (sp8) begin
                hi++;
                if (!found) begin
                    lat = n;
                    found = 1'b1;
                end
            end
        end
        chk("step_seen", int'(found), 1);
        chk("step_latency_in_range", int'(lat >= 6 && lat <= 8), 1);
        chk("step_width", hi, 1);
        btnd = 1'b0; tick(1);
        btnd = 1'b1; tick(2);
        btnd = 1'b0; tick(1);
        btnd = 1'b1; tick(1);
        btnd = 1'b0; tick(15);
        chk("debounce_total_steps", pulses - p0, 1);
        model_step(1'b1, 1'b1);
        check_model("debounce");

        // Asynchronous reset between edges clears state immediately
        do_reset();
        bits6[0] = 1; bits6[1] = 0; bits6[2] = 1; bits6[3] = 0; bits6[4] = 1; bits6[5] = 1;
        foreach (bits6[i]) press(bits6[i], 1'b1);
        bits5[0] = 0; bits5[1] = 1; bits5[2] = 0; bits5[3] = 1; bits5[4] = 0;
        for (int i = 0; i < 4; i++) press(bits5[i], 1'b1);
        chk("pre_reset_led", int'(led8), 5);
        chk("pre_reset_cnt", int'(cnt8), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_led",  int'(led8),   0);
        chk("async_reset_led0", int'(led0_8), 0);
        chk("async_reset_cnt",  int'(cnt8),   0);
        tick(1);
        rst = 1'b0;
        model_reset();
        tick(2);
        press(1'b1, 1'b1);
        chk("post_reset_led", int'(led8), 1);
        check_model("post_reset");

        // Saturation of the narrow counter over five overlapping matches
        do_reset();
        foreach (bits6[i]) press(bits6[i], 1'b1);
        chk("sat_cnt_m0", int'(cnt2), exp2[0]);
        chk("sat_led0_m0", int'(led0_2), 1);
        for (int m = 1; m < 5; m++) begin
            foreach (bits5[i]) begin
                press(i == 4 ? 1'b1 : bits5[i], 1'b1);
                if (i < 4) chk($sformatf("sat_led0_low_%0d_%0d", m, i), int'(led0_2), 0);
            end
            chk($sformatf("sat_cnt_m%0d", m), int'(cnt2), exp2[m]);
            chk($sformatf("sat_led0_m%0d", m), int'(led0_2), 1);
            chk($sformatf("sat_led_m%0d", m), int'(led2), 1);
        end

        // Randomised steps, biased toward extending the current prefix
        do_reset();
        for (int i = 0; i < 80; i++) begin
            bit d, o;
            if ($urandom_range(0, 9) < 7) d = patv[PL - 1 - mled];
            else d = 1'($urandom_range(0, 1));
            o = ($urandom_range(0, 3) != 0);
            press(d, o);
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
